// File: rtl/binary_serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
//   start  master->slave  request, sampled by the slave only when idle
//   A, B   master->slave  minuend / subtrahend, WIDTH bits
//   Bin    master->slave  borrow-in
//   busy   slave->master  operation in flight (start ignored)
//   done   slave->master  one-cycle pulse, Diff/Bout valid
//   Diff   slave->master  result, held until the next accepted start
//   Bout   slave->master  borrow-out, held with Diff
interface binary_serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             Bout;

  modport master (
    output start, A, B, Bin,
    input  busy, done, Diff, Bout
  );

  modport slave (
    input  start, A, B, Bin,
    output busy, done, Diff, Bout
  );
endinterface

// File: rtl/binary_serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: {Bout,Diff} = A - B - Bin (unsigned, modulo 2^WIDTH).
// One full-subtractor cell processes operands LSB-first, one bit per clock.
//   clk  rising-edge clock
//   rst  synchronous reset, active-high; aborts any operation in flight
//   bus  slave side of binary_serial_subtractor_if (start/A/B/Bin in,
//        busy/done/Diff/Bout out)
// Timing: start accepted at edge t -> WIDTH SHIFT cycles -> DONE cycle with
// done=1 and Diff/Bout already valid; next start is accepted after DONE.
module binary_serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  binary_serial_subtractor_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sa_q, sa_d;
  logic [WIDTH-1:0]   sb_q, sb_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               borrow_q, borrow_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;

  // Full-subtractor cell on the current LSBs.
  logic d_bit;
  logic borrow_nxt;

  always_comb begin
    d_bit      = sa_q[0] ^ sb_q[0] ^ borrow_q;
    borrow_nxt = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & borrow_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sa_d     = bus.A;
          sb_d     = bus.B;
          borrow_d = bus.Bin;
          res_d    = '0;
          cnt_d    = '0;
          state_d  = SHIFT;
        end
      end

      SHIFT: begin
        sa_d     = sa_q >> 1;
        sb_d     = sb_q >> 1;
        // Result fills from the MSB so the first (LSB) bit ends at bit 0.
        res_d    = {d_bit, res_q[WIDTH-1:1]};
        borrow_d = borrow_nxt;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          // Publish on the edge that enters DONE so Diff/Bout are valid
          // during the done pulse itself.
          diff_d  = {d_bit, res_q[WIDTH-1:1]};
          bout_d  = borrow_nxt;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.Diff = diff_q;
  assign bus.Bout = bout_q;

endmodule

// File: tb/tb_binary_serial_subtractor.sv
module tb_binary_serial_subtractor;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  binary_serial_subtractor_if #(.WIDTH(W)) bsi ();

  binary_serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bsi)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [W:0] exp_q[$];

  always @(negedge clk) if (bsi.done === 1'b1) done_cnt++;

  task automatic wait_idle();
    int cyc = 0;
    while (bsi.busy !== 1'b0 && cyc < 4 * W) begin
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (bsi.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_wait: busy=%b required 0", bsi.busy);
    end
  endtask

  // Scoreboarded operation: push golden on start, pop/compare on done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    int cyc;
    bit stable;
    logic [W-1:0] prev_diff;
    logic prev_bout;
    logic [W:0] exp, got;
    wait_idle();
    prev_diff = bsi.Diff;
    prev_bout = bsi.Bout;
    bsi.A = a; bsi.B = b; bsi.Bin = bin; bsi.start = 1'b1;
    exp_q.push_back({1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin});
    @(posedge clk); #1;
    bsi.start = 1'b0;
    // Operands scrambled after capture must not affect the result.
    bsi.A = ~a; bsi.B = ~b; bsi.Bin = ~bin;
    cyc = 0;
    stable = 1'b1;
    while (bsi.done !== 1'b1 && cyc < 3 * W) begin
      if (bsi.Diff !== prev_diff || bsi.Bout !== prev_bout) stable = 1'b0;
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (bsi.done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout a=%0d b=%0d bin=%0d: done=%b required 1", a, b, bin, bsi.done);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    checks++;
    if (cyc !== W) begin
      errors++;
      $display("FAIL latency a=%0d b=%0d bin=%0d: %0d cycles required %0d", a, b, bin, cyc, W);
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL hold_stable a=%0d b=%0d bin=%0d: outputs changed before done", a, b, bin);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty a=%0d b=%0d bin=%0d", a, b, bin);
    end else begin
      exp = exp_q.pop_front();
      got = {bsi.Bout, bsi.Diff};
      if (got !== exp) begin
        errors++;
        $display("FAIL result a=%0d b=%0d bin=%0d: Bout/Diff=%b/%0d required %b/%0d",
                 a, b, bin, got[W], got[W-1:0], exp[W], exp[W-1:0]);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (bsi.done !== 1'b0 || bsi.busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse a=%0d b=%0d bin=%0d: done=%b busy=%b required 0 0", a, b, bin, bsi.done, bsi.busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bsi.start = 1'b0; bsi.A = '0; bsi.B = '0; bsi.Bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bsi.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: %b required 0", bsi.busy); end
    checks++; if (bsi.done !== 1'b0) begin errors++; $display("FAIL reset_done: %b required 0", bsi.done); end
    checks++; if (bsi.Diff !== '0) begin errors++; $display("FAIL reset_diff: %0d required 0", bsi.Diff); end
    checks++; if (bsi.Bout !== 1'b0) begin errors++; $display("FAIL reset_bout: %b required 0", bsi.Bout); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_op(4'd9, 4'd6, 1'b0);
    run_op(4'd3, 4'd3, 1'b1);
    run_op(4'd4, 4'd5, 1'b0);
  endtask

  task automatic test_boundaries();
    run_op(4'd12, 4'd11, 1'b1);
    run_op(4'd0, 4'd15, 1'b1);
    run_op(4'd15, 4'd0, 1'b0);
  endtask

  task automatic test_start_held();
    int base, cyc;
    logic [W:0] exp, got;
    wait_idle();
    base = done_cnt;
    bsi.A = 4'd5; bsi.B = 4'd2; bsi.Bin = 1'b0; bsi.start = 1'b1;
    exp_q.push_back(5'd3);
    @(posedge clk); #1;
    bsi.A = 4'd1; bsi.B = 4'd7; bsi.Bin = 1'b1;   // start stays high
    cyc = 0;
    while (bsi.done !== 1'b1 && cyc < 3 * W) begin @(posedge clk); #1; cyc++; end
    bsi.start = 1'b0;
    checks++;
    if (bsi.done !== 1'b1) begin
      errors++;
      $display("FAIL held_timeout: done=%b required 1", bsi.done);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      exp = exp_q.pop_front();
      got = {bsi.Bout, bsi.Diff};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL held_result: Bout/Diff=%b/%0d required %b/%0d", got[W], got[W-1:0], exp[W], exp[W-1:0]);
      end
    end
    repeat (2 * W) @(posedge clk);
    #1;
    checks++;
    if (done_cnt - base !== 1) begin
      errors++;
      $display("FAIL held_done_count: %0d required 1", done_cnt - base);
    end
  endtask

  task automatic test_reset_mid_op();
    int base;
    wait_idle();
    bsi.A = 4'd9; bsi.B = 4'd6; bsi.Bin = 1'b0; bsi.start = 1'b1;
    @(posedge clk); #1;
    bsi.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    base = done_cnt;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (bsi.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: %b required 0", bsi.busy); end
    checks++; if (bsi.done !== 1'b0) begin errors++; $display("FAIL midrst_done: %b required 0", bsi.done); end
    checks++; if (bsi.Diff !== '0) begin errors++; $display("FAIL midrst_diff: %0d required 0", bsi.Diff); end
    checks++; if (bsi.Bout !== 1'b0) begin errors++; $display("FAIL midrst_bout: %b required 0", bsi.Bout); end
    repeat (2 * W) @(posedge clk);
    #1;
    checks++;
    if (done_cnt !== base) begin
      errors++;
      $display("FAIL midrst_no_done: %0d pulses required 0", done_cnt - base);
    end
    run_op(4'd7, 4'd2, 1'b1);
  endtask

  task automatic test_back_to_back();
    int base;
    logic [W-1:0] a, b;
    base = done_cnt;
    for (int ia = 0; ia < (1 << W); ia++) begin
      for (int ib = 0; ib < (1 << W); ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          a = W'(ia);
          b = W'(ib);
          run_op(a, b, ic[0]);
        end
      end
    end
    #1;
    checks++;
    if (done_cnt - base !== 512) begin
      errors++;
      $display("FAIL exhaustive_done_count: %0d required 512", done_cnt - base);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d entries required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_start_held();
    test_reset_mid_op();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
